regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core, with two write-back ports and NUM_RD read ports.
- Replaces the single-write, dual-read register file.
- Adds a write-to-read bypass and a per-register busy scoreboard, which the issue stage uses to detect RAW hazards.
- Sits between decode/issue (read + issue ports) and write-back: the ALU drives write port 0, load/store drives write port 1.

Parameters:
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- DATA_W, 32, register data width.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy cleared combinationally; 0 = reads see registered state only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- w0_en  in  1  write port 0 enable (ALU write-back).
- w0_addr  in  ADDR_W  write port 0 destination.
- w0_data  in  DATA_W  write port 0 data.
- w1_en  in  1  write port 1 enable (load write-back).
- w1_addr  in  ADDR_W  write port 1 destination.
- w1_data  in  DATA_W  write port 1 data.
- rs_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- rs_busy  out  NUM_RD  per read port: source register has a pending write.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- busy_any  out  1  OR of all scoreboard bits; used to drain before fence.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- On a clk edge with rst=1: every register is cleared to 0 and every scoreboard bit to 0, all in a single cycle. rst has priority over all writes and issues in that cycle.
- Outputs after reset: read_data=0, rs_busy=0, busy_any=0.
- Register 0: hardwired zero.
  - Writes to address 0 are discarded.
  - Issue to address 0 does not set busy.
  - Reads of address 0 return 0 and busy 0, regardless of bypass.
- Writes: storage updates at the clk edge, latency 1.
  - If w0_en and w1_en target the same nonzero address, w1_data is stored (port 1 wins).
  - Different addresses: both are written.
- Reads: combinational, zero latency.
  - BYPASS=0: read_data[k] = stored value.
  - BYPASS=1, priority order: w1 match (w1_en, w1_addr==rs_addr[k], nonzero) → w1_data; else w0 match → w0_data; else stored value.
- Scoreboard: one bit per register, all updated at the clk edge.
  - Clear: w0_en or w1_en to address a clears bit a.
  - Set: iss_en sets bit iss_rd.
  - Set and clear of the same register in the same cycle: set wins, because the new producer is outstanding.
  - Issue to an already-busy register: bit stays 1 (WAW is tolerated; the issue stage serialises).
- rs_busy[k]:
  - BYPASS=0: equals scoreboard[rs_addr[k]].
  - BYPASS=1: the above AND NOT (any same-cycle write to rs_addr[k]).
  - Always 0 for address 0.
- busy_any: OR of the registered scoreboard bits. It does not reflect same-cycle writes or issues.
- Reset mid-operation: pending busy bits are lost and in-flight write-backs in the reset cycle are dropped. The pipeline flushes alongside.
- No internal FSM beyond storage and scoreboard. All state is in the two arrays.

Decomposition:
- Shared package rv_pkg holds:
  - REG_ZERO = 0
  - default ADDR_W and DATA_W constants
  - function for packed-port slicing
- One sub-module, rf_read_port: a single read port containing the bypass mux and busy gating, instantiated NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top level.

Test Plan:
- Reset clearing: write x5=0x5, x6=0x1; assert rst 1 cycle; read rs=5, rs=6 → both 0, busy_any=0.
- Dual write, same address: w0 x7=0xAAAA_0000 and w1 x7=0x0000_BBBB in one cycle; next cycle read x7 → 0x0000_BBBB. With BYPASS=1 the same-cycle read also returns 0x0000_BBBB.
- x0 immunity: w0 x0=0xFFFF_FFFF and iss x0; read rs=0 → data 0, rs_busy 0, busy_any 0.
- Scoreboard: iss x3 → next cycle rs_busy=1 for a read of x3. w1 x3=0x10 → same cycle rs_busy=0 (BYPASS=1) or 1 (BYPASS=0), data 0x10 (BYPASS=1). Following cycle busy_any=0.
- Set/clear collision: x4 busy; in one cycle w0 x4=0x22 and iss x4 → next cycle x4=0x22, busy still 1.
- NUM_RD=3 regression: read x1, x2, x31 simultaneously after writing 0x1, 0x2, 0x1F → packed read_data matches per slice. Repeat with BYPASS=0 and check one-cycle visibility.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Imported by the storage top level and by each read-port slice.
package rv_pkg;

    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

    // Low bit of port k inside a packed bus of w-bit lanes.
    function automatic int unsigned slice_lo(
        input int unsigned k,
        input int unsigned w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: same-cycle write forwarding and
// scoreboard busy gating, with x0 forced to zero and never busy.
module rf_read_port
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [DATA_W-1:0] stored_data_i,
    input  logic              stored_busy_i,
    input  logic              w0_en_i,
    input  logic [ADDR_W-1:0] w0_addr_i,
    input  logic [DATA_W-1:0] w0_data_i,
    input  logic              w1_en_i,
    input  logic [ADDR_W-1:0] w1_addr_i,
    input  logic [DATA_W-1:0] w1_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    localparam bit BYP = (BYPASS != 0);

    logic is_zero;
    logic w0_hit;
    logic w1_hit;

    assign is_zero = (rs_addr_i == ADDR_W'(REG_ZERO));
    assign w0_hit  = BYP && w0_en_i && (w0_addr_i == rs_addr_i) && !is_zero;
    assign w1_hit  = BYP && w1_en_i && (w1_addr_i == rs_addr_i) && !is_zero;

    // Port 1 has priority, matching the write-collision rule in storage.
    always_comb begin
        rd_data_o = stored_data_i;
        rd_busy_o = stored_busy_i;
        if (is_zero) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else begin
            if (w1_hit) begin
                rd_data_o = w1_data_i;
            end else if (w0_hit) begin
                rd_data_o = w0_data_i;
            end
            if (w0_hit || w1_hit) begin
                rd_busy_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Dual write-back, NUM_RD read register file with a per-register busy
// scoreboard used by issue for RAW hazard detection.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w0_en,
    input  logic [ADDR_W-1:0]        w0_addr,
    input  logic [DATA_W-1:0]        w0_data,
    input  logic                     w1_en,
    input  logic [ADDR_W-1:0]        w1_addr,
    input  logic [DATA_W-1:0]        w1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     busy_any
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][DATA_W-1:0] regs_d;
    logic [NREG-1:0]             busy_q;
    logic [NREG-1:0]             busy_d;

    always_comb begin
        regs_d = regs_q;
        if (w0_en && (w0_addr != ZERO_A)) begin
            regs_d[w0_addr] = w0_data;
        end
        if (w1_en && (w1_addr != ZERO_A)) begin
            regs_d[w1_addr] = w1_data;
        end
    end

    // Set after clear: a fresh producer outranks the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (w0_en) begin
            busy_d[w0_addr] = 1'b0;
        end
        if (w1_en) begin
            busy_d[w1_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[ZERO_A] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_any = |busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;

        assign a = rs_addr[slice_lo(k, ADDR_W) +: ADDR_W];

        rf_read_port #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .BYPASS (BYPASS)
        ) u_port (
            .rs_addr_i     (a),
            .stored_data_i (regs_q[a]),
            .stored_busy_i (busy_q[a]),
            .w0_en_i       (w0_en),
            .w0_addr_i     (w0_addr),
            .w0_data_i     (w0_data),
            .w1_en_i       (w1_en),
            .w1_addr_i     (w1_addr),
            .w1_data_i     (w1_data),
            .rd_data_o     (read_data[slice_lo(k, DATA_W) +: DATA_W]),
            .rd_busy_o     (rs_busy[k])
        );
    end

endmodule
